// File: rtl/mips_trace_collector.sv
// In-order trace FIFO for GRF and DM write events of the single-cycle MIPS core.
// Two write slots per cycle (GRF first, then DM), first-word-fall-through read side.
module mips_trace_collector #(
    parameter int unsigned DEPTH       = 16,
    parameter bit          FILTER_ZERO = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     grf_we,
    input  logic [31:0]              grf_pc,
    input  logic [4:0]               grf_addr,
    input  logic [31:0]              grf_wdata,
    input  logic                     dm_we,
    input  logic [31:0]              dm_pc,
    input  logic [31:0]              dm_addr,
    input  logic [31:0]              dm_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_kind,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    rec_t          mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;

    logic          pop, g_ev, d_ev, push_g, push_d;
    logic [1:0]    n_drop;
    logic [AW+1:0] free;
    logic [16:0]   drop_sum;
    rec_t          g_rec, d_rec, head;

    always_comb begin
        pop   = (count_q != '0) && out_ready;
        g_ev  = grf_we && !(FILTER_ZERO && (grf_addr == 5'd0));
        d_ev  = dm_we;
        // A pop in this cycle frees its slot for a push in the same cycle.
        free  = (AW+2)'(DEPTH) - {1'b0, count_q} + (AW+2)'(pop);
        g_rec = '{kind: 1'b0, pc: grf_pc, addr: {27'b0, grf_addr}, data: grf_wdata};
        d_rec = '{kind: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_wdata};

        push_g = 1'b0;
        push_d = 1'b0;
        n_drop = 2'd0;
        if (free >= (AW+2)'(2)) begin
            push_g = g_ev;
            push_d = d_ev;
        end else if (free == (AW+2)'(1)) begin
            push_g = g_ev;
            push_d = d_ev && !g_ev;
            n_drop = {1'b0, g_ev && d_ev};
        end else begin
            n_drop = {1'b0, g_ev} + {1'b0, d_ev};
        end

        count_d  = count_q + (AW+1)'(push_g) + (AW+1)'(push_d) - (AW+1)'(pop);
        wptr_d   = wptr_q + AW'(push_g) + AW'(push_d);
        rptr_d   = rptr_q + AW'(pop);
        ovf_d    = ovf_q || (n_drop != 2'd0);
        drop_sum = {1'b0, drop_q} + 17'(n_drop);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 16'd0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Storage carries no reset; unread slots never reach the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (push_g) mem_q[wptr_q] <= g_rec;
            if (push_d) mem_q[wptr_q + AW'(push_g)] <= d_rec;
        end
    end

    always_comb begin
        head      = mem_q[rptr_q];
        out_valid = (count_q != '0);
        out_kind  = out_valid ? head.kind : 1'b0;
        out_pc    = out_valid ? head.pc   : 32'd0;
        out_addr  = out_valid ? head.addr : 32'd0;
        out_data  = out_valid ? head.data : 32'd0;
    end

    assign count    = count_q;
    assign overflow = ovf_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_mips_trace_collector.sv
// Bench for mips_trace_collector: directed scenarios plus random traffic, all
// compared against a queue-based reference model of the trace FIFO.
module tb_mips_trace_collector;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        grf_we, dm_we, out_ready;
    logic [31:0] grf_pc, grf_wdata, dm_pc, dm_addr, dm_wdata;
    logic [4:0]  grf_addr;
    logic        out_valid, out_kind, overflow;
    logic [31:0] out_pc, out_addr, out_data;
    logic [4:0]  count;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    rec_t mq[$];
    bit   m_ovf;
    int   m_drops;

    mips_trace_collector #(.DEPTH(DEPTH), .FILTER_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_add(input rec_t r);
        if (mq.size() < DEPTH) mq.push_back(r);
        else begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
        end
    endtask

    // Reader takes the head first, then GRF and DM events claim space in that order.
    task automatic model_edge();
        rec_t r;
        if (!reset) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            if (mq.size() != 0 && out_ready) mq.delete(0);
            if (grf_we && grf_addr != 5'd0) begin
                r = '{kind: 1'b0, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_wdata};
                model_add(r);
            end
            if (dm_we) begin
                r = '{kind: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_wdata};
                model_add(r);
            end
        end
    endtask

    task automatic check_all(input string tag);
        rec_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
        chk({tag, ".kind"},  32'(out_kind), 32'(h.kind));
        chk({tag, ".pc"},    out_pc, h.pc);
        chk({tag, ".addr"},  out_addr, h.addr);
        chk({tag, ".data"},  out_data, h.data);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
        chk({tag, ".drops"}, 32'(drop_cnt), 32'(m_drops));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        grf_we = 1'b0;
        dm_we  = 1'b0;
    endtask

    task automatic grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] v);
        grf_we = 1'b1; grf_pc = pc; grf_addr = a; grf_wdata = v;
    endtask

    task automatic dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] v);
        dm_we = 1'b1; dm_pc = pc; dm_addr = a; dm_wdata = v;
    endtask

    initial begin
        reset = 1'b0; out_ready = 1'b0;
        grf_we = 1'b0; grf_pc = '0; grf_addr = '0; grf_wdata = '0;
        dm_we = 1'b0; dm_pc = '0; dm_addr = '0; dm_wdata = '0;
        m_ovf = 1'b0; m_drops = 0;

        // Reset state, with events present that must be ignored.
        grf(32'h3000, 5'd3, 32'hDEAD);
        dm(32'h3000, 32'h4, 32'hBEEF);
        cycle("rst0");
        cycle("rst1");
        chk("rst.count", 32'(count), 32'd0);
        reset = 1'b1;
        idle();

        // Single GRF record, held while the reader stalls.
        grf(32'h3000, 5'd8, 32'h1234);
        cycle("s1.push");
        idle();
        chk("s1.pc", out_pc, 32'h3000);
        chk("s1.addr", out_addr, 32'h8);
        chk("s1.data", out_data, 32'h1234);
        for (int i = 0; i < 3; i++) cycle("s1.hold");
        chk("s1.count", 32'(count), 32'd1);

        reset = 1'b0; cycle("s2.rst"); reset = 1'b1;

        // Both events in one cycle: GRF drains before DM.
        grf(32'h3004, 5'd9, 32'h5);
        dm(32'h3004, 32'h10, 32'hFF);
        cycle("s2.push");
        idle();
        chk("s2.count", 32'(count), 32'd2);
        out_ready = 1'b1;
        cycle("s2.pop1");
        chk("s2.kind", 32'(out_kind), 32'd1);
        chk("s2.daddr", out_addr, 32'h10);
        chk("s2.ddata", out_data, 32'hFF);
        cycle("s2.pop2");

        // Writes to r0 are filtered, not dropped.
        grf(32'h3008, 5'd0, 32'h77);
        cycle("s3.r0");
        idle();
        chk("s3.drops", 32'(drop_cnt), 32'd0);

        // 17 pushes into 16 slots, then drain in order.
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            grf(32'h3100 + 32'(4 * i), 5'd1 + 5'(i % 30), 32'(i));
            cycle("s4.fill");
        end
        idle();
        chk("s4.count", 32'(count), 32'd16);
        chk("s4.ovf", 32'(overflow), 32'd1);
        chk("s4.drops", 32'(drop_cnt), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("s4.order", out_data, 32'(i));
            cycle("s4.drain");
        end

        // Full FIFO: simultaneous pop and push keeps count at 16 with no drop.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            grf(32'h3200, 5'd2, 32'h100 + 32'(i));
            cycle("s5.fill");
        end
        out_ready = 1'b1;
        grf(32'h3240, 5'd4, 32'hAA);
        cycle("s5.swap");
        idle();
        chk("s5.count", 32'(count), 32'd16);
        chk("s5.drops", 32'(drop_cnt), 32'd1);
        cycle("s5.pop");
        out_ready = 1'b0;
        grf(32'h3244, 5'd5, 32'hBB);
        dm(32'h3244, 32'h20, 32'hCC);
        cycle("s5.half");
        idle();
        chk("s5.drops2", 32'(drop_cnt), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) cycle("s5.drain");
        chk("s5.empty", 32'(out_valid), 32'd0);

        // Reset mid-stream while the reader toggles.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            grf(32'h3300, 5'd6, 32'(i));
            cycle("s6.fill");
        end
        reset = 1'b0;
        out_ready = 1'b1;
        dm(32'h3300, 32'h40, 32'h9);
        cycle("s6.rst");
        reset = 1'b1;
        idle();
        out_ready = 1'b0;
        chk("s6.count", 32'(count), 32'd0);
        chk("s6.data", out_data, 32'd0);
        grf(32'h3000, 5'd8, 32'h1234);
        cycle("s6.again");
        idle();
        chk("s6.pc", out_pc, 32'h3000);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) != 0);
            out_ready = ($urandom_range(0, 99) < 45);
            grf_we    = ($urandom_range(0, 99) < 60);
            grf_pc    = $urandom;
            grf_addr  = 5'($urandom_range(0, 31));
            grf_wdata = $urandom;
            dm_we     = ($urandom_range(0, 99) < 35);
            dm_pc     = $urandom;
            dm_addr   = $urandom;
            dm_wdata  = $urandom;
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
